iccm_sram_arbiter: RTL and testbench



---
 rtl/iccm_arb_pkg.sv | 20 ++
 rtl/iccm_prog_fifo.sv | 52 +++++
 rtl/iccm_sram_arbiter.sv | 167 ++++++++++++++++
 tb/tb_iccm_sram_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iccm_arb_pkg.sv
// Shared types and sizing for the instruction SRAM port-0 arbiter.
package iccm_arb_pkg;

  localparam int IccmAw       = 10;
  localparam int IccmDw       = 32;
  localparam int IccmMaxStall = 8;
  localparam int StallW       = $clog2(IccmMaxStall + 1);

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    PROG   = 2'd1,
    DRAIN  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [IccmAw-1:0] addr;
    logic [IccmDw-1:0] wdata;
  } prog_wr_t;

endpackage

// File: rtl/iccm_prog_fifo.sv
// Small synchronous buffer for boot-programmer writes; a push while full is
// accepted only when the head is popped in the same cycle.
module iccm_prog_fifo
  import iccm_arb_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push,
  input  logic     pop,
  input  prog_wr_t din,
  output prog_wr_t head,
  output logic     full,
  output logic     empty,
  output logic     last
);

  localparam int PtrW = $clog2(Depth);

  logic [PtrW:0] wr_ptr;
  logic [PtrW:0] rd_ptr;
  logic [PtrW:0] count;
  logic          do_push;
  logic          do_pop;
  prog_wr_t      mem [Depth];

  // Extra pointer bit distinguishes full from empty when the slot indices match.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PtrW] != rd_ptr[PtrW]) &&
                   (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);
  assign last    = (count == {{PtrW{1'b0}}, 1'b1});
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[PtrW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[PtrW-1:0]] <= din;
  end

endmodule

// File: rtl/iccm_sram_arbiter.sv
// Shares instruction SRAM port 0 between the TL-UL adapter and the UART boot
// programmer, buffering programmer writes and sequencing programming mode.
module iccm_sram_arbiter
  import iccm_arb_pkg::*;
#(
  parameter int AW        = IccmAw,
  parameter int DW        = IccmDw,
  parameter int FifoDepth = 2,
  parameter int MaxStall  = IccmMaxStall
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          prog_mode_i,
  input  logic          prog_we_i,
  input  logic [AW-1:0] prog_addr_i,
  input  logic [DW-1:0] prog_wdata_i,
  input  logic          bus_req_i,
  input  logic          bus_we_i,
  input  logic [AW-1:0] bus_addr_i,
  input  logic [DW-1:0] bus_wdata_i,
  input  logic [3:0]    bus_wmask_i,
  output logic          bus_gnt_o,
  output logic          bus_rvalid_o,
  output logic [DW-1:0] bus_rdata_o,
  output logic          sram_csb_o,
  output logic          sram_web_o,
  output logic [3:0]    sram_wmask_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [DW-1:0] sram_wdata_o,
  input  logic [DW-1:0] sram_rdata_i,
  output logic          prog_overflow_o,
  output logic          busy_o
);

  arb_state_e        state;
  arb_state_e        state_next;
  logic [StallW-1:0] stall_cnt;
  logic [StallW-1:0] stall_next;
  logic              stall_max;

  prog_wr_t          prog_wr;
  prog_wr_t          fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_last;
  logic              fifo_pop;
  logic              fifo_drop;
  logic              drained;

  logic              bus_win;
  logic              gnt_p1;
  logic              rd_p1;
  logic              prog_mode_p1;
  logic              mode_rise;

  assign prog_wr = '{addr: prog_addr_i, wdata: prog_wdata_i};

  iccm_prog_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (prog_we_i),
    .pop    (fifo_pop),
    .din    (prog_wr),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .last   (fifo_last)
  );

  assign stall_max = (stall_cnt == StallW'(MaxStall));
  assign fifo_drop = prog_we_i && fifo_full && !fifo_pop;
  assign drained   = fifo_empty || (fifo_last && fifo_pop && !prog_we_i);
  assign mode_rise = prog_mode_i && !prog_mode_p1;

  // Port ownership is forced idle while reset is held so nothing reaches the macro.
  always_comb begin
    bus_win  = 1'b0;
    fifo_pop = 1'b0;
    if (rst_ni) begin
      case (state)
        NORMAL: begin
          if (!fifo_empty && (!bus_req_i || stall_max)) fifo_pop = 1'b1;
          else                                           bus_win  = bus_req_i;
        end
        PROG, DRAIN: fifo_pop = !fifo_empty;
        default: ;
      endcase
    end
  end

  always_comb begin
    sram_csb_o   = 1'b1;
    sram_web_o   = 1'b1;
    sram_wmask_o = 4'h0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    if (bus_win) begin
      sram_csb_o   = 1'b0;
      sram_web_o   = !bus_we_i;
      sram_wmask_o = bus_we_i ? bus_wmask_i : 4'h0;
      sram_addr_o  = bus_addr_i;
      sram_wdata_o = bus_wdata_i;
    end else if (fifo_pop) begin
      sram_csb_o   = 1'b0;
      sram_web_o   = 1'b0;
      sram_wmask_o = 4'hF;
      sram_addr_o  = fifo_head.addr;
      sram_wdata_o = fifo_head.wdata;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      NORMAL: if (prog_mode_i) state_next = PROG;
      PROG: begin
        if (!prog_mode_i && !prog_we_i) state_next = fifo_empty ? NORMAL : DRAIN;
      end
      DRAIN: begin
        if (prog_mode_i)  state_next = PROG;
        else if (drained) state_next = NORMAL;
      end
      default: state_next = NORMAL;
    endcase
  end

  // Only grants that actually delay a waiting prog write count toward the limit.
  always_comb begin
    stall_next = stall_cnt;
    if (fifo_pop)                                 stall_next = '0;
    else if (bus_win && !fifo_empty && !stall_max) stall_next = stall_cnt + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= NORMAL;
      stall_cnt       <= '0;
      prog_mode_p1    <= 1'b0;
      prog_overflow_o <= 1'b0;
    end else begin
      state        <= state_next;
      stall_cnt    <= stall_next;
      prog_mode_p1 <= prog_mode_i;
      if (fifo_drop)      prog_overflow_o <= 1'b1;
      else if (mode_rise) prog_overflow_o <= 1'b0;
    end
  end

  // Response stage: one cycle after the grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_p1 <= 1'b0;
      rd_p1  <= 1'b0;
    end else begin
      gnt_p1 <= bus_win;
      rd_p1  <= bus_win && !bus_we_i;
    end
  end

  assign bus_gnt_o    = bus_win;
  assign bus_rvalid_o = gnt_p1;
  assign bus_rdata_o  = (gnt_p1 && rd_p1) ? sram_rdata_i : '0;
  assign busy_o       = (state != NORMAL) || !fifo_empty;

endmodule

// File: tb/tb_iccm_sram_arbiter.sv
// Directed scoreboard bench for iccm_sram_arbiter: stimulus queues expected SRAM
// accesses and bus responses; a negedge monitor pops and compares them.
module tb_iccm_sram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        prog_mode;
  logic        prog_we;
  logic [9:0]  prog_addr;
  logic [31:0] prog_wdata;
  logic        bus_req;
  logic        bus_we;
  logic [9:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        sram_csb;
  logic        sram_web;
  logic [3:0]  sram_wmask;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        prog_overflow;
  logic        busy;

  typedef struct packed {
    logic        web;
    logic [3:0]  wmask;
    logic [9:0]  addr;
    logic [31:0] wdata;
  } acc_t;

  acc_t        exp_acc[$];
  logic [31:0] exp_rsp[$];
  acc_t        mon_acc;
  logic [31:0] mon_rsp;
  int          checks;
  int          failures;

  iccm_sram_arbiter dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .prog_mode_i     (prog_mode),
    .prog_we_i       (prog_we),
    .prog_addr_i     (prog_addr),
    .prog_wdata_i    (prog_wdata),
    .bus_req_i       (bus_req),
    .bus_we_i        (bus_we),
    .bus_addr_i      (bus_addr),
    .bus_wdata_i     (bus_wdata),
    .bus_wmask_i     (bus_wmask),
    .bus_gnt_o       (bus_gnt),
    .bus_rvalid_o    (bus_rvalid),
    .bus_rdata_o     (bus_rdata),
    .sram_csb_o      (sram_csb),
    .sram_web_o      (sram_web),
    .sram_wmask_o    (sram_wmask),
    .sram_addr_o     (sram_addr),
    .sram_wdata_o    (sram_wdata),
    .sram_rdata_i    (sram_rdata),
    .prog_overflow_o (prog_overflow),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic push_acc(input logic web, input logic [3:0] m, input logic [9:0] a,
                          input logic [31:0] d);
    acc_t e;
    e.web = web; e.wmask = m; e.addr = a; e.wdata = d;
    exp_acc.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (!sram_csb) begin
        if (exp_acc.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_sram_access actual addr=0x%0h web=%0b required none", sram_addr, sram_web);
        end else begin
          mon_acc = exp_acc.pop_front();
          chk("sram_web",   sram_web,   mon_acc.web);
          chk("sram_wmask", sram_wmask, mon_acc.wmask);
          chk("sram_addr",  sram_addr,  mon_acc.addr);
          chk("sram_wdata", sram_wdata, mon_acc.wdata);
        end
      end
      if (bus_rvalid) begin
        if (exp_rsp.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rvalid actual rdata=0x%0h required none", bus_rdata);
        end else begin
          mon_rsp = exp_rsp.pop_front();
          chk("bus_rdata", bus_rdata, mon_rsp);
        end
      end
    end
  end

  // Queues two prog writes in NORMAL behind a held bus read, enters PROG for one
  // cycle (one pop), leaves with one entry still queued: returns at start of DRAIN.
  task automatic build_drain(input logic [9:0] a, input logic [31:0] d);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 10'h200; bus_wdata = '0;
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    push_acc(1'b1, 4'h0, 10'h200, 32'h0); exp_rsp.push_back(32'hDEADBEEF);
    @(negedge clk); chk("bd_q1_gnt", bus_gnt, 1'b1); tick();
    prog_addr = a + 10'd1; prog_wdata = d + 32'd1;
    push_acc(1'b1, 4'h0, 10'h200, 32'h0); exp_rsp.push_back(32'hDEADBEEF);
    @(negedge clk); chk("bd_q2_gnt", bus_gnt, 1'b1); tick();
    prog_we = 1'b0; prog_mode = 1'b1;
    push_acc(1'b1, 4'h0, 10'h200, 32'h0); exp_rsp.push_back(32'hDEADBEEF);
    @(negedge clk); chk("bd_rise_gnt", bus_gnt, 1'b1); tick();
    prog_mode = 1'b0;
    push_acc(1'b0, 4'hF, a, d);
    @(negedge clk); chk("bd_prog_gnt", bus_gnt, 1'b0); tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; prog_mode = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 10'h055; bus_wdata = '0; bus_wmask = 4'hF;
    sram_rdata = '0;

    // Reset values, with a bus request held to show the port stays idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_csb", sram_csb, 1'b1);     chk("rst_web", sram_web, 1'b1);
    chk("rst_wmask", sram_wmask, 4'h0); chk("rst_addr", sram_addr, 10'h0);
    chk("rst_wdata", sram_wdata, 32'h0); chk("rst_gnt", bus_gnt, 1'b0);
    chk("rst_rvalid", bus_rvalid, 1'b0); chk("rst_ovf", prog_overflow, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    bus_req = 1'b0; rst_n = 1'b1;
    tick();

    // Bus read, write, read back to back
    sram_rdata = 32'hDEADBEEF;
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 10'h005;
    push_acc(1'b1, 4'h0, 10'h005, 32'h0); exp_rsp.push_back(32'hDEADBEEF);
    @(negedge clk); chk("rd_gnt", bus_gnt, 1'b1); tick();
    bus_we = 1'b1; bus_addr = 10'h3FF; bus_wdata = 32'h12345678; bus_wmask = 4'h3;
    push_acc(1'b0, 4'h3, 10'h3FF, 32'h12345678); exp_rsp.push_back(32'h0);
    @(negedge clk); chk("wr_gnt", bus_gnt, 1'b1); chk("rd_rvalid", bus_rvalid, 1'b1); tick();
    bus_we = 1'b0; bus_addr = 10'h006; bus_wdata = '0; bus_wmask = 4'hF;
    push_acc(1'b1, 4'h0, 10'h006, 32'h0); exp_rsp.push_back(32'hDEADBEEF);
    @(negedge clk); chk("rd2_gnt", bus_gnt, 1'b1); tick();
    bus_req = 1'b0;
    @(negedge clk); chk("idle_gnt", bus_gnt, 1'b0); tick();
    @(negedge clk); chk("idle_rvalid", bus_rvalid, 1'b0); tick();

    // Mode entry keeps the access granted in that cycle; PROG writes, bus held off
    prog_mode = 1'b1; bus_req = 1'b1; bus_we = 1'b0; bus_addr = 10'h100;
    push_acc(1'b1, 4'h0, 10'h100, 32'h0); exp_rsp.push_back(32'hDEADBEEF);
    @(negedge clk); chk("entry_gnt", bus_gnt, 1'b1); tick();
    for (int i = 0; i < 4; i++) begin
      prog_we = 1'b1; prog_addr = 10'(i); prog_wdata = 32'hA0000000 + 32'(i);
      push_acc(1'b0, 4'hF, 10'(i), 32'hA0000000 + 32'(i));
      @(negedge clk); chk("prog_gnt", bus_gnt, 1'b0); tick();
      prog_we = 1'b0;
      repeat (3) begin
        @(negedge clk); chk("prog_gnt", bus_gnt, 1'b0); tick();
      end
    end
    chk("prog_ovf", prog_overflow, 1'b0);
    chk("prog_busy", busy, 1'b1);

    // Leaving PROG with a write still queued goes through DRAIN
    prog_we = 1'b1; prog_addr = 10'h010; prog_wdata = 32'h11110000;
    push_acc(1'b0, 4'hF, 10'h010, 32'h11110000);
    @(negedge clk); chk("exit_a_gnt", bus_gnt, 1'b0); tick();
    prog_addr = 10'h011; prog_wdata = 32'h22220000; prog_mode = 1'b0;
    push_acc(1'b0, 4'hF, 10'h011, 32'h22220000);
    @(negedge clk); chk("exit_b_gnt", bus_gnt, 1'b0); tick();
    prog_we = 1'b0;
    @(negedge clk); chk("exit_c_gnt", bus_gnt, 1'b0); chk("exit_c_busy", busy, 1'b1); tick();
    @(negedge clk); chk("drain_gnt", bus_gnt, 1'b0); chk("drain_busy", busy, 1'b1);
    chk("drain_csb", sram_csb, 1'b1);
    push_acc(1'b1, 4'h0, 10'h100, 32'h0); exp_rsp.push_back(32'hDEADBEEF);
    tick();
    @(negedge clk); chk("normal_gnt", bus_gnt, 1'b1); chk("normal_busy", busy, 1'b0); tick();
    bus_req = 1'b0;
    @(negedge clk); tick();

    // DRAIN that actually pops, then the held request is granted
    build_drain(10'h0A0, 32'hB0000000);
    push_acc(1'b0, 4'hF, 10'h0A1, 32'hB0000001);
    @(negedge clk); chk("drain_pop_gnt", bus_gnt, 1'b0); chk("drain_pop_busy", busy, 1'b1); tick();
    push_acc(1'b1, 4'h0, 10'h200, 32'h0); exp_rsp.push_back(32'hDEADBEEF);
    @(negedge clk); chk("after_drain_gnt", bus_gnt, 1'b1); chk("after_drain_busy", busy, 1'b0); tick();
    bus_req = 1'b0;
    @(negedge clk); tick();

    // Starvation limit: 8 grants while a write waits, one pop, then grants
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 10'h020;
    for (int c = 0; c <= 10; c++) begin
      prog_we = (c == 0); prog_addr = 10'h030; prog_wdata = 32'h5555AAAA;
      if (c == 9) push_acc(1'b0, 4'hF, 10'h030, 32'h5555AAAA);
      else begin
        push_acc(1'b1, 4'h0, 10'h020, 32'h0); exp_rsp.push_back(32'hDEADBEEF);
      end
      @(negedge clk); chk("stall_gnt", bus_gnt, (c != 9)); tick();
    end
    bus_req = 1'b0; prog_we = 1'b0;
    @(negedge clk); tick();

    // Three consecutive writes in PROG: no drop with two entries
    prog_mode = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      prog_we = 1'b1; prog_addr = 10'h050 + 10'(i); prog_wdata = 32'hC1 + 32'(i);
      push_acc(1'b0, 4'hF, 10'h050 + 10'(i), 32'hC1 + 32'(i));
      tick();
    end
    prog_we = 1'b0;
    @(negedge clk); chk("prog3_ovf", prog_overflow, 1'b0); tick();
    prog_mode = 1'b0; tick();

    // Overflow with pops blocked by the bus in NORMAL; cleared by next mode rise
    bus_req = 1'b1; bus_addr = 10'h040;
    for (int i = 0; i < 3; i++) begin
      prog_we = 1'b1; prog_addr = 10'h060 + 10'(i); prog_wdata = 32'hD0 + 32'(i);
      push_acc(1'b1, 4'h0, 10'h040, 32'h0); exp_rsp.push_back(32'hDEADBEEF);
      @(negedge clk); chk("ovf_pre", prog_overflow, 1'b0); tick();
    end
    prog_we = 1'b0; bus_req = 1'b0;
    push_acc(1'b0, 4'hF, 10'h060, 32'hD0);
    @(negedge clk); chk("ovf_set", prog_overflow, 1'b1); tick();
    push_acc(1'b0, 4'hF, 10'h061, 32'hD1);
    @(negedge clk); chk("ovf_busy", busy, 1'b1); tick();
    prog_mode = 1'b1;
    @(negedge clk); chk("ovf_sticky", prog_overflow, 1'b1); chk("ovf_empty", busy, 1'b0); tick();
    prog_mode = 1'b0;
    @(negedge clk); chk("ovf_clear", prog_overflow, 1'b0); tick();
    @(negedge clk); tick();

    // Asynchronous reset in DRAIN with one write left
    build_drain(10'h070, 32'h77770000);
    #2 rst_n = 1'b0;
    #1;
    chk("rstd_csb", sram_csb, 1'b1); chk("rstd_gnt", bus_gnt, 1'b0);
    chk("rstd_rvalid", bus_rvalid, 1'b0); chk("rstd_busy", busy, 1'b0);
    @(posedge clk); #1;
    bus_req = 1'b0; rst_n = 1'b1;
    @(negedge clk); chk("post_rst_csb", sram_csb, 1'b1); chk("post_rst_busy", busy, 1'b0); tick();

    // Reset after a grant suppresses its rvalid
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 10'h080;
    push_acc(1'b1, 4'h0, 10'h080, 32'h0);
    @(negedge clk); chk("inflight_gnt", bus_gnt, 1'b1);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    bus_req = 1'b0; rst_n = 1'b1;
    @(negedge clk); chk("inflight_rvalid", bus_rvalid, 1'b0); tick();
    @(negedge clk); chk("inflight_rvalid2", bus_rvalid, 1'b0); tick();

    chk("acc_queue_left", exp_acc.size(), 0);
    chk("rsp_queue_left", exp_rsp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
